interp_fir: RTL and testbench
=============================

INTERP_FIR -- requirements
Module: interp_fir

Interface
REQ-001 Parameter TAP_COUNT, default 16, total filter taps; SHALL be a multiple of INTERP_FACTOR*MULT_PER_CYCLE.
REQ-002 Parameter INTERP_FACTOR, default 2, output samples produced per input sample (L).
REQ-003 Parameter MULT_PER_CYCLE, default 2, multiplies per MAC cycle (M).
REQ-004 Parameter DATA_WIDTH, default 32, sample and coefficient width, two's complement.
REQ-005 Parameter QUANT_BITS, default 10, fractional bits of samples and taps.
REQ-006 Parameter TAPS, default all zero, TAP_COUNT x DATA_WIDTH signed coefficient array.
REQ-007 clock  input  1  sole clock, rising edge.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 in_data  input  DATA_WIDTH  head of upstream first-word-fall-through FIFO.
REQ-010 in_empty  input  1  upstream FIFO empty.
REQ-011 in_rd_en  output  1  pop strobe; sample accepted in any cycle it is high.
REQ-012 out_data  output  DATA_WIDTH  interpolated output sample.
REQ-013 out_full  input  1  downstream FIFO full.
REQ-014 out_wr_en  output  1  push strobe; out_data written in any cycle it is high.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Definitions: P = TAP_COUNT/L taps per phase; C = P/M MAC cycles per phase.
REQ-017 States: IDLE, MAC, OUTPUT; single FSM; no other states.
REQ-018 IDLE: in_rd_en = !in_empty, combinational; on acceptance, history shifts (hist[k] <= hist[k-1], hist[0] <= in_data), phase <= 0, acc <= 0, -> MAC.
REQ-019 IDLE with in_empty high: in_rd_en low, state and history unchanged.
REQ-020 MAC: each cycle adds M terms for phase p, cycle c: term(k) = (TAPS[k*L+p] * hist[k]) >>> QUANT_BITS, k = c*M .. c*M+M-1.
REQ-021 Product formed at full 2*DATA_WIDTH signed width, arithmetic shift (floor), truncated to DATA_WIDTH; acc wraps modulo 2^DATA_WIDTH, no saturation.
REQ-022 MAC lasts exactly C cycles, then -> OUTPUT with out_data <= final acc, registered.
REQ-023 OUTPUT: out_wr_en = !out_full, combinational; out_data stable while out_full high; no state change while out_full high.
REQ-024 OUTPUT write with phase < L-1: phase <= phase+1, acc <= 0, -> MAC.
REQ-025 OUTPUT write with phase = L-1: -> IDLE.
REQ-026 in_rd_en never high outside IDLE; out_wr_en never high outside OUTPUT; never both high in one cycle.
REQ-027 Unstalled timing: accept at T, out_wr_en for phase p at T+(p+1)(C+1), IDLE at T+L(C+1)+1; defaults: writes T+5, T+10, next accept no earlier than T+11.
REQ-028 Output sequence per input: phases 0..L-1 in order, exactly L writes, none dropped or duplicated.

Reset
REQ-029 On reset high at a clock edge: state IDLE, history all zero, acc 0, phase 0, out_data 0.
REQ-030 During and after reset: in_rd_en, out_wr_en and busy low until the FSM leaves IDLE.
REQ-031 Reset mid-MAC or mid-OUTPUT aborts the computation; no further writes for the aborted sample.

Verification
REQ-032 Impulse, defaults, TAPS[k] = k+1: inputs 1024, then 0 x7 -> outputs 1,2,3,...,16 in order, then zeros.
REQ-033 Latency: in_rd_en at cycle 0, out_full low -> out_wr_en at cycles 5 and 10 only; in_rd_en high again at cycle 11 when in_empty low.
REQ-034 Backpressure: out_full high for 20 cycles at first OUTPUT -> out_wr_en low, out_data constant, in_rd_en low; write occurs in the cycle out_full falls.
REQ-035 Sign: TAPS[0] = 1024, others 0, input -1024 -> outputs -1024 then 0; input 3 with TAPS[0]=1 -> output 0 (floor of 3/1024).
REQ-036 Starvation: in_empty high for 50 cycles -> in_rd_en low, busy low, no writes; history unchanged.
REQ-037 Reset at cycle 3 of first MAC -> no writes follow; next impulse of 1024 reproduces REQ-032 from the start.

Source files
------------

// File: rtl/interp_fir_if.sv
// Stream handshake between interp_fir and its upstream/downstream FWFT FIFOs.
interface interp_fir_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_full;
  logic                  out_wr_en;
  logic                  busy;

  modport master (
    output in_data, in_empty, out_full,
    input  in_rd_en, out_data, out_wr_en, busy
  );

  modport slave (
    input  in_data, in_empty, out_full,
    output in_rd_en, out_data, out_wr_en, busy
  );
endinterface

// File: rtl/interp_fir.sv
// Polyphase interpolating FIR: each input sample yields INTERP_FACTOR outputs,
// each phase accumulated MULT_PER_CYCLE taps per cycle.
//
// state  | meaning
// IDLE   | waiting for an input sample; popping it shifts the history
// MAC    | accumulating the current phase over C cycles
// OUTPUT | presenting the phase result until downstream accepts it
module interp_fir #(
  parameter int TAP_COUNT      = 16,
  parameter int INTERP_FACTOR  = 2,
  parameter int MULT_PER_CYCLE = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int QUANT_BITS     = 10,
  parameter logic signed [DATA_WIDTH-1:0] TAPS [TAP_COUNT] = '{default: '0}
) (
  input  logic        clock,
  input  logic        reset,
  interp_fir_if.slave bus
);

  localparam int L     = INTERP_FACTOR;
  localparam int M     = MULT_PER_CYCLE;
  localparam int P     = TAP_COUNT / L;
  localparam int C     = P / M;
  localparam int CW    = (C > 1) ? $clog2(C) : 1;
  localparam int PW    = (L > 1) ? $clog2(L) : 1;
  localparam int HW    = (P > 1) ? $clog2(P) : 1;
  localparam int TW    = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
  localparam int PRODW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, MAC, OUTPUT} state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic signed [DATA_WIDTH-1:0] hist [P];
  logic [DATA_WIDTH-1:0]        acc;
  logic [DATA_WIDTH-1:0]        mac_sum;
  logic [DATA_WIDTH-1:0]        out_data_r;
  logic [PW-1:0]                phase;
  logic [CW-1:0]                mac_cnt;
  logic                         mac_done;
  logic                         last_phase;
  logic                         accept;
  logic                         push;

  assign mac_done   = (mac_cnt == '0);
  assign last_phase = (phase == PW'(L - 1));
  assign accept     = (state == IDLE) && !bus.in_empty;
  assign push       = (state == OUTPUT) && !bus.out_full;

  // mac_cnt counts down, so the taps of a phase are visited from the highest
  // group to the lowest; the modular sum does not depend on the order.
  always_comb begin
    logic signed [PRODW-1:0] prod;
    logic [HW-1:0]           hidx;
    logic [TW-1:0]           tidx;
    prod    = '0;
    hidx    = '0;
    tidx    = '0;
    mac_sum = acc;
    for (int j = 0; j < M; j++) begin
      hidx    = HW'(int'(mac_cnt) * M + j);
      tidx    = TW'(int'(hidx) * L + int'(phase));
      prod    = PRODW'(TAPS[tidx]) * PRODW'(hist[hidx]);
      mac_sum = mac_sum + DATA_WIDTH'(prod >>> QUANT_BITS);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (mac_done) state_nxt = OUTPUT;
      OUTPUT:  if (push) state_nxt = last_phase ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are held low while reset is asserted so an aborted sample can
  // neither pop nor push in the reset cycle itself.
  always_comb begin
    bus.in_rd_en  = 1'b0;
    bus.out_wr_en = 1'b0;
    bus.busy      = 1'b0;
    if (!reset) begin
      bus.in_rd_en  = accept;
      bus.out_wr_en = push;
      bus.busy      = (state != IDLE);
    end
  end

  assign bus.out_data = out_data_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < P; k++) hist[k] <= '0;
      acc        <= '0;
      phase      <= '0;
      mac_cnt    <= '0;
      out_data_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int k = P - 1; k > 0; k--) hist[k] <= hist[k-1];
            hist[0] <= bus.in_data;
            phase   <= '0;
            acc     <= '0;
            mac_cnt <= CW'(C - 1);
          end
        end
        MAC: begin
          acc     <= mac_sum;
          mac_cnt <= mac_cnt - 1'b1;
          if (mac_done) out_data_r <= mac_sum;
        end
        OUTPUT: begin
          if (push && !last_phase) begin
            phase   <= phase + 1'b1;
            acc     <= '0;
            mac_cnt <= CW'(C - 1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_fir.sv
// Self-checking bench for interp_fir: directed vectors plus randomized samples
// against a polyphase arithmetic model.
module tb_interp_fir;

  localparam int DW = 32;
  localparam int NT = 16;
  localparam int L  = 2;
  localparam int P  = NT / L;
  localparam int QB = 10;

  localparam logic signed [DW-1:0] TAPS_A [NT] = '{
    32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8,
    32'sd9, 32'sd10, 32'sd11, 32'sd12, 32'sd13, 32'sd14, 32'sd15, 32'sd16};
  localparam logic signed [DW-1:0] TAPS_B [NT] = '{
    32'sd1024, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0,
    32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  interp_fir_if #(.DATA_WIDTH(DW)) bus_a ();
  interp_fir_if #(.DATA_WIDTH(DW)) bus_b ();

  interp_fir #(.TAPS(TAPS_A)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  interp_fir #(.TAPS(TAPS_B)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  int          errors = 0;
  int          checks = 0;
  longint      taps_a [NT];
  int          hist_a [P];
  logic [31:0] got_q [$];

  // Output of phase p: sum over k of floor(tap[k*L+p] * x[n-k] / 2^QB), mod 2^32.
  function automatic logic [31:0] model_out(input int p);
    logic [31:0] acc;
    longint      prod;
    acc = '0;
    for (int k = 0; k < P; k++) begin
      prod = taps_a[k*L+p] * longint'(hist_a[k]);
      acc  = acc + 32'(prod >>> QB);
    end
    return acc;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < P; k++) hist_a[k] = 0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    bus_a.in_empty = 1'b1; bus_a.out_full = 1'b0;
    bus_b.in_empty = 1'b1; bus_b.out_full = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_model();
  endtask

  // Pushes one sample into dut_a and collects its L outputs into got_q.
  task automatic feed_a(input int d, input bit rnd_full, output int to);
    int guard;
    int n;
    to = 0;
    guard = 0;
    @(negedge clock);
    bus_a.in_data = d; bus_a.in_empty = 1'b0; bus_a.out_full = 1'b0;
    #1;
    while (bus_a.in_rd_en !== 1'b1 && guard < 100) begin
      @(negedge clock); #1; guard++;
    end
    if (guard >= 100) begin
      to = 1; bus_a.in_empty = 1'b1;
      return;
    end
    @(posedge clock);
    for (int k = P - 1; k > 0; k--) hist_a[k] = hist_a[k-1];
    hist_a[0] = d;
    n = 0;
    guard = 0;
    while (n < L && guard < 200) begin
      @(negedge clock);
      bus_a.in_empty = 1'b1;
      bus_a.out_full = rnd_full ? ($urandom_range(0, 2) == 0) : 1'b0;
      #1;
      if (bus_a.out_wr_en === 1'b1) begin
        got_q.push_back(bus_a.out_data);
        n++;
      end
      guard++;
    end
    bus_a.out_full = 1'b0;
    if (n < L) to = 1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    bus_a.in_empty = 1'b0; bus_a.in_data = 32'h5a5a; bus_a.out_full = 1'b0;
    bus_b.in_empty = 1'b0; bus_b.in_data = 32'h1234; bus_b.out_full = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (bus_a.in_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus_a.in_rd_en); end
    checks++;
    if (bus_a.out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus_a.out_wr_en); end
    checks++;
    if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    checks++;
    if (bus_a.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus_a.out_data); end
    checks++;
    if (bus_b.in_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en_b: got %b want 0", bus_b.in_rd_en); end
    @(negedge clock);
    bus_a.in_empty = 1'b1; bus_b.in_empty = 1'b1; reset = 1'b0;
    clear_model();
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (bus_a.busy !== 1'b0 || bus_a.in_rd_en !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got busy=%b rd=%b want 0 0", bus_a.busy, bus_a.in_rd_en);
    end
  endtask

  task automatic test_impulse();
    int          to;
    logic [31:0] g;
    logic [31:0] want;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      got_q.delete();
      feed_a((i == 0) ? 1024 : 0, 1'b0, to);
      checks++;
      if (to != 0) begin errors++; $display("FAIL impulse_timeout: sample %0d got %0d outputs want %0d", i, got_q.size(), L); end
      for (int p = 0; p < L; p++) begin
        want = (i < 8) ? 32'(i * L + p + 1) : 32'd0;
        g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (g !== want) begin errors++; $display("FAIL impulse_out[%0d]: got %0d want %0d", i * L + p, g, want); end
      end
    end
  endtask

  task automatic test_latency();
    logic [12:0] rd_mask;
    logic [12:0] wr_mask;
    logic [12:0] busy_mask;
    int          both;
    int          guard;
    apply_reset();
    rd_mask = '0; wr_mask = '0; busy_mask = '0; both = 0;
    @(negedge clock);
    bus_a.in_data = 32'd5; bus_a.in_empty = 1'b0; bus_a.out_full = 1'b0;
    for (int t = 0; t < 13; t++) begin
      #1;
      rd_mask[t]   = bus_a.in_rd_en;
      wr_mask[t]   = bus_a.out_wr_en;
      busy_mask[t] = bus_a.busy;
      if (bus_a.in_rd_en === 1'b1 && bus_a.out_wr_en === 1'b1) both++;
      @(negedge clock);
    end
    bus_a.in_empty = 1'b1;
    checks++;
    if (rd_mask !== 13'h0801) begin errors++; $display("FAIL latency_rd: got %h want 0801", rd_mask); end
    checks++;
    if (wr_mask !== 13'h0420) begin errors++; $display("FAIL latency_wr: got %h want 0420", wr_mask); end
    checks++;
    if (busy_mask !== 13'h17fe) begin errors++; $display("FAIL latency_busy: got %h want 17fe", busy_mask); end
    checks++;
    if (both != 0) begin errors++; $display("FAIL latency_exclusive: got %0d overlapping cycles want 0", both); end
    guard = 0;
    while (bus_a.busy !== 1'b0 && guard < 40) begin
      @(negedge clock); #1; guard++;
    end
    checks++;
    if (guard >= 40) begin errors++; $display("FAIL latency_drain: got busy=%b want 0", bus_a.busy); end
  endtask

  task automatic test_backpressure();
    int          d;
    logic [31:0] exp0;
    logic [31:0] exp1;
    int          stall_bad;
    int          extra;
    logic        rd0, wr25, wr30, busy31;
    logic [31:0] d25, d30;
    apply_reset();
    d = int'($urandom);
    stall_bad = 0; extra = 0; exp0 = '0; exp1 = '0;
    rd0 = 1'b0; wr25 = 1'b0; wr30 = 1'b0; busy31 = 1'b1; d25 = '0; d30 = '0;
    @(negedge clock);
    bus_a.in_data = d; bus_a.in_empty = 1'b0; bus_a.out_full = 1'b1;
    for (int t = 0; t < 32; t++) begin
      if (t == 25) begin bus_a.out_full = 1'b0; bus_a.in_empty = 1'b1; end
      #1;
      if (t == 0) begin
        rd0 = bus_a.in_rd_en;
        for (int k = P - 1; k > 0; k--) hist_a[k] = hist_a[k-1];
        hist_a[0] = d;
        exp0 = model_out(0);
        exp1 = model_out(1);
      end
      if (t >= 1 && t < 5 && bus_a.in_rd_en !== 1'b0) stall_bad++;
      if (t >= 5 && t < 25 &&
          (bus_a.out_wr_en !== 1'b0 || bus_a.in_rd_en !== 1'b0 || bus_a.out_data !== exp0)) stall_bad++;
      if (t == 25) begin wr25 = bus_a.out_wr_en; d25 = bus_a.out_data; end
      if (t > 25 && t < 30 && bus_a.out_wr_en !== 1'b0) extra++;
      if (t == 30) begin wr30 = bus_a.out_wr_en; d30 = bus_a.out_data; end
      if (t == 31) busy31 = bus_a.busy;
      @(negedge clock);
    end
    checks++;
    if (rd0 !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", rd0); end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_stall: got %0d bad cycles want 0", stall_bad); end
    checks++;
    if (wr25 !== 1'b1 || d25 !== exp0) begin errors++; $display("FAIL bp_release: got wr=%b data=%h want 1 %h", wr25, d25, exp0); end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL bp_extra_write: got %0d want 0", extra); end
    checks++;
    if (wr30 !== 1'b1 || d30 !== exp1) begin errors++; $display("FAIL bp_phase1: got wr=%b data=%h want 1 %h", wr30, d30, exp1); end
    checks++;
    if (busy31 !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy=%b want 0", busy31); end
  endtask

  task automatic test_sign();
    int          to;
    int          n;
    int          guard;
    bit          acc_seen;
    logic [31:0] got_b [2];
    logic [31:0] g;
    apply_reset();
    got_b[0] = 'x; got_b[1] = 'x;
    n = 0; guard = 0; acc_seen = 0;
    @(negedge clock);
    bus_b.in_data = 32'hffff_fc00; bus_b.in_empty = 1'b0; bus_b.out_full = 1'b0;
    while (n < 2 && guard < 100) begin
      #1;
      if (bus_b.in_rd_en === 1'b1) acc_seen = 1;
      if (bus_b.out_wr_en === 1'b1) begin got_b[n] = bus_b.out_data; n++; end
      @(negedge clock);
      if (acc_seen) bus_b.in_empty = 1'b1;
      guard++;
    end
    bus_b.in_empty = 1'b1;
    checks++;
    if (n != 2) begin errors++; $display("FAIL sign_count: got %0d want 2", n); end
    checks++;
    if (got_b[0] !== 32'hffff_fc00) begin errors++; $display("FAIL sign_neg: got %h want fffffc00", got_b[0]); end
    checks++;
    if (got_b[1] !== 32'd0) begin errors++; $display("FAIL sign_zero: got %h want 0", got_b[1]); end
    got_q.delete();
    feed_a(3, 1'b0, to);
    feed_a(-1, 1'b0, to);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL floor_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (g !== ((i < 2) ? 32'd0 : 32'hffff_ffff)) begin
        errors++; $display("FAIL floor_out[%0d]: got %h want %h", i, g, (i < 2) ? 32'd0 : 32'hffff_ffff);
      end
    end
  endtask

  task automatic test_starvation();
    int          to;
    int          bad;
    logic [31:0] g;
    apply_reset();
    got_q.delete();
    feed_a(1024, 1'b0, to);
    got_q.delete();
    bad = 0;
    @(negedge clock);
    bus_a.in_empty = 1'b1;
    for (int t = 0; t < 50; t++) begin
      #1;
      if (bus_a.in_rd_en !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.out_wr_en !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL starve_quiet: got %0d active cycles want 0", bad); end
    feed_a(0, 1'b0, to);
    for (int p = 0; p < L; p++) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (g !== 32'(p + 3)) begin errors++; $display("FAIL starve_hist[%0d]: got %0d want %0d", p, g, p + 3); end
    end
  endtask

  task automatic test_reset_mid_mac();
    int          to;
    int          bad;
    logic        rd0;
    logic [31:0] g;
    apply_reset();
    @(negedge clock);
    bus_a.in_data = 1024; bus_a.in_empty = 1'b0; bus_a.out_full = 1'b0;
    #1;
    rd0 = bus_a.in_rd_en;
    @(negedge clock);
    bus_a.in_empty = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (rd0 !== 1'b1) begin errors++; $display("FAIL abort_accept: got %b want 1", rd0); end
    checks++;
    if (bus_a.busy !== 1'b0 || bus_a.out_wr_en !== 1'b0) begin
      errors++; $display("FAIL abort_in_reset: got busy=%b wr=%b want 0 0", bus_a.busy, bus_a.out_wr_en);
    end
    @(negedge clock);
    reset = 1'b0;
    clear_model();
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (bus_a.out_wr_en !== 1'b0 || bus_a.busy !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_no_write: got %0d active cycles want 0", bad); end
    got_q.delete();
    for (int i = 0; i < 8; i++) feed_a((i == 0) ? 1024 : 0, 1'b0, to);
    checks++;
    if (got_q.size() != 16) begin errors++; $display("FAIL abort_reimpulse_count: got %0d want 16", got_q.size()); end
    for (int i = 0; i < 16; i++) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (g !== 32'(i + 1)) begin errors++; $display("FAIL abort_reimpulse[%0d]: got %0d want %0d", i, g, i + 1); end
    end
  endtask

  task automatic test_random();
    int          to;
    int          d;
    logic [31:0] g;
    logic [31:0] want;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      got_q.delete();
      d = int'($urandom);
      feed_a(d, 1'b1, to);
      checks++;
      if (to != 0) begin errors++; $display("FAIL random_timeout: sample %0d got %0d outputs want %0d", i, got_q.size(), L); end
      for (int p = 0; p < L; p++) begin
        want = model_out(p);
        g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (g !== want) begin errors++; $display("FAIL random_out[%0d.%0d]: got %h want %h", i, p, g, want); end
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
  endtask

  initial begin
    bus_a.in_data = '0; bus_a.in_empty = 1'b1; bus_a.out_full = 1'b0;
    bus_b.in_data = '0; bus_b.in_empty = 1'b1; bus_b.out_full = 1'b0;
    for (int i = 0; i < NT; i++) taps_a[i] = longint'(i + 1);
    clear_model();
    test_reset();
    test_impulse();
    test_latency();
    test_backpressure();
    test_sign();
    test_starvation();
    test_reset_mid_mac();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion within 500000 ns want completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
